// File: rtl/uc_coordena_asteroides_tiros_pkg.sv
// Shared definitions for the asteroid/shot round coordinator: state codes,
// default slot counts and derived index widths.
package uc_coordena_asteroides_tiros_pkg;

  localparam int N_AST_DEF   = 16;
  localparam int N_TIROS_DEF = 8;
  localparam int DIV_MOV_DEF = 4;

  // Width of an index into n slots; never below 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AST_W_DEF  = idx_w(N_AST_DEF);
  localparam int TIRO_W_DEF = idx_w(N_TIROS_DEF);

  typedef enum logic [3:0] {
    OCIOSO     = 4'h0,
    MOVE_TIROS = 4'h1,
    MOVE_AST   = 4'h2,
    NAVE       = 4'h3,
    BATIDA     = 4'h4,
    COLISAO    = 4'h5,
    ACERTO     = 4'h6,
    PROX_AST   = 4'h7,
    FIM        = 4'h8,
    ERRO       = 4'hF
  } estado_t;

endpackage

// File: rtl/uc_coordena_asteroides_tiros_if.sv
// Handshake and datapath bus between the main UC / slot datapath and the
// round coordinator. slave = coordinator side, master = driver side.
interface uc_coordena_asteroides_tiros_if #(
  parameter int AST_W  = 4,
  parameter int TIRO_W = 3
);
  logic              reset_maquinas;
  logic              inicia;
  logic              vidas;
  logic              asteroide_ativo;
  logic              tiro_ativo;
  logic              colisao_ast_tiro;
  logic              colisao_nave;
  logic [AST_W-1:0]  addr_asteroide;
  logic [TIRO_W-1:0] addr_tiro;
  logic              move_tiro;
  logic              move_asteroide;
  logic              desativa_asteroide;
  logic              desativa_tiro;
  logic              pontua;
  logic              decrementa_vida;
  logic              fim;
  logic [3:0]        db_estado;

  modport slave (
    input  reset_maquinas, inicia, vidas, asteroide_ativo, tiro_ativo,
           colisao_ast_tiro, colisao_nave,
    output addr_asteroide, addr_tiro, move_tiro, move_asteroide,
           desativa_asteroide, desativa_tiro, pontua, decrementa_vida,
           fim, db_estado
  );

  modport master (
    output reset_maquinas, inicia, vidas, asteroide_ativo, tiro_ativo,
           colisao_ast_tiro, colisao_nave,
    input  addr_asteroide, addr_tiro, move_tiro, move_asteroide,
           desativa_asteroide, desativa_tiro, pontua, decrementa_vida,
           fim, db_estado
  );
endinterface

// File: rtl/uc_coordena_asteroides_tiros_contador.sv
// Slot index counter: synchronous clear beats enable, never wraps on its own;
// 'last' flags the final slot so the FSM decides when to clear.
module contador_indice #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] idx,
  output logic         last
);

  // Index register: clear has priority, increment otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       idx <= '0;
    else if (clear)  idx <= '0;
    else if (enable) idx <= idx + 1'b1;
  end

  assign last = (idx == W'(N - 1));

endmodule

// File: rtl/uc_coordena_asteroides_tiros.sv
// Round coordinator: advances shots, periodically advances asteroids, then
// checks every active asteroid against the ship and each active shot.
module uc_coordena_asteroides_tiros
  import uc_coordena_asteroides_tiros_pkg::*;
#(
  parameter int N_AST   = N_AST_DEF,
  parameter int N_TIROS = N_TIROS_DEF,
  parameter int DIV_MOV = DIV_MOV_DEF
) (
  input logic clock,
  input logic reset,
  uc_coordena_asteroides_tiros_if.slave bus
);

  localparam int AST_W  = idx_w(N_AST);
  localparam int TIRO_W = idx_w(N_TIROS);
  localparam int DIV_W  = idx_w(DIV_MOV);

  estado_t           estado;
  logic [DIV_W-1:0]  div_cnt;
  logic [AST_W-1:0]  ast_idx;
  logic [TIRO_W-1:0] tiro_idx;
  logic              ast_last, tiro_last;
  logic              ast_clr, ast_en, tiro_clr, tiro_en;
  logic              acerto_agora;

  assign acerto_agora = bus.tiro_ativo & bus.colisao_ast_tiro;

  // Index control per state; reset_maquinas and OCIOSO park both at slot 0.
  always_comb begin
    ast_clr  = 1'b0;
    ast_en   = 1'b0;
    tiro_clr = 1'b0;
    tiro_en  = 1'b0;
    case (estado)
      OCIOSO: begin
        ast_clr  = 1'b1;
        tiro_clr = 1'b1;
      end
      MOVE_TIROS: begin
        tiro_clr = tiro_last;
        tiro_en  = 1'b1;
      end
      MOVE_AST: begin
        ast_clr = ast_last;
        ast_en  = 1'b1;
      end
      NAVE:     tiro_clr = bus.asteroide_ativo & ~bus.colisao_nave;
      COLISAO:  tiro_en  = ~acerto_agora & ~tiro_last;
      PROX_AST: ast_en   = ~ast_last;
      default: ;
    endcase
    if (bus.reset_maquinas) begin
      ast_clr  = 1'b1;
      tiro_clr = 1'b1;
    end
  end

  contador_indice #(.N(N_AST), .W(AST_W)) u_ast_idx (
    .clock  (clock),
    .reset  (reset),
    .clear  (ast_clr),
    .enable (ast_en),
    .idx    (ast_idx),
    .last   (ast_last)
  );

  contador_indice #(.N(N_TIROS), .W(TIRO_W)) u_tiro_idx (
    .clock  (clock),
    .reset  (reset),
    .clear  (tiro_clr),
    .enable (tiro_en),
    .idx    (tiro_idx),
    .last   (tiro_last)
  );

  // Round FSM plus move divider; the ship is tested before any shot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado  <= OCIOSO;
      div_cnt <= '0;
    end else if (bus.reset_maquinas) begin
      estado  <= OCIOSO;
      div_cnt <= '0;
    end else begin
      case (estado)
        OCIOSO:     if (bus.inicia) estado <= MOVE_TIROS;
        MOVE_TIROS: if (tiro_last)
                      estado <= (div_cnt == DIV_W'(DIV_MOV - 1)) ? MOVE_AST : NAVE;
        MOVE_AST:   if (ast_last) estado <= NAVE;
        NAVE: begin
          if (!bus.asteroide_ativo)  estado <= PROX_AST;
          else if (bus.colisao_nave) estado <= BATIDA;
          else                       estado <= COLISAO;
        end
        BATIDA:     estado <= bus.vidas ? PROX_AST : FIM;
        COLISAO: begin
          if (acerto_agora)   estado <= ACERTO;
          else if (tiro_last) estado <= PROX_AST;
        end
        ACERTO:     estado <= PROX_AST;
        PROX_AST:   estado <= ast_last ? FIM : NAVE;
        FIM: begin
          div_cnt <= (div_cnt == DIV_W'(DIV_MOV - 1)) ? '0 : div_cnt + 1'b1;
          estado  <= OCIOSO;
        end
        ERRO:       estado <= OCIOSO;
        default:    estado <= ERRO;
      endcase
    end
  end

  // Strobes decode the state register and must line up with the current
  // slot address and its same-cycle flags, so they are not delayed further.
  always_comb begin
    bus.move_tiro          = (estado == MOVE_TIROS) & bus.tiro_ativo;
    bus.move_asteroide     = (estado == MOVE_AST) & bus.asteroide_ativo;
    bus.desativa_asteroide = (estado == BATIDA) | (estado == ACERTO);
    bus.desativa_tiro      = (estado == ACERTO);
    bus.pontua             = (estado == ACERTO);
    bus.decrementa_vida    = (estado == BATIDA);
    bus.fim                = (estado == FIM);
    bus.db_estado          = estado;
    bus.addr_asteroide     = ast_idx;
    bus.addr_tiro          = tiro_idx;
  end

endmodule

// File: tb/tb_uc_coordena_asteroides_tiros.sv
// Bench for the round coordinator: slot datapath model with hit/ship
// collisions, table-driven round scenarios plus reset and multi-round cases.
module tb_uc_coordena_asteroides_tiros;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  uc_coordena_asteroides_tiros_if #(.AST_W(4), .TIRO_W(3)) bus ();

  uc_coordena_asteroides_tiros dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Slot datapath model: initial active masks, kills applied on strobes.
  logic [15:0] ast_init  = '0;
  logic [7:0]  tiro_init = '0;
  logic [15:0] ast_kill;
  logic [7:0]  tiro_kill;
  logic        kill_clr = 1'b1;
  int          hit_a  = -1;
  int          hit_t  = -1;
  int          nave_a = -1;

  assign bus.asteroide_ativo  = ast_init[bus.addr_asteroide] & ~ast_kill[bus.addr_asteroide];
  assign bus.tiro_ativo       = tiro_init[bus.addr_tiro] & ~tiro_kill[bus.addr_tiro];
  assign bus.colisao_ast_tiro = (int'(bus.addr_asteroide) == hit_a) && (int'(bus.addr_tiro) == hit_t);
  assign bus.colisao_nave     = (int'(bus.addr_asteroide) == nave_a);

  always @(posedge clock) begin
    if (kill_clr) begin
      ast_kill  <= '0;
      tiro_kill <= '0;
    end else begin
      if (bus.desativa_asteroide) ast_kill[bus.addr_asteroide] <= 1'b1;
      if (bus.desativa_tiro)      tiro_kill[bus.addr_tiro]     <= 1'b1;
    end
  end

  // Round monitor
  logic mon = 1'b0, mon_clr = 1'b0;
  int n_pont, n_decr, n_mt, n_ma, n_mast_st, max_a, col_at_nave;
  int last_pont_a, last_pont_t, last_decr_a, fim_prev, prev_db;

  always @(negedge clock) begin
    if (mon_clr) begin
      n_pont = 0; n_decr = 0; n_mt = 0; n_ma = 0; n_mast_st = 0; max_a = 0;
      col_at_nave = 0; last_pont_a = -1; last_pont_t = -1; last_decr_a = -1;
      fim_prev = -1; prev_db = 0;
    end else if (mon) begin
      if (bus.pontua) begin
        n_pont++; last_pont_a = int'(bus.addr_asteroide); last_pont_t = int'(bus.addr_tiro);
      end
      if (bus.decrementa_vida) begin
        n_decr++; last_decr_a = int'(bus.addr_asteroide);
      end
      n_mt += int'(bus.move_tiro);
      n_ma += int'(bus.move_asteroide);
      if (bus.db_estado == 4'h2) n_mast_st++;
      if (int'(bus.addr_asteroide) > max_a) max_a = int'(bus.addr_asteroide);
      if (bus.db_estado == 4'h5 && int'(bus.addr_asteroide) == nave_a) col_at_nave++;
      if (bus.fim) fim_prev = prev_db;
      prev_db = int'(bus.db_estado);
    end
  end

  int ncmp = 0, nbad = 0;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int outs_packed();
    return int'({bus.move_tiro, bus.move_asteroide, bus.desativa_asteroide,
                 bus.desativa_tiro, bus.pontua, bus.decrementa_vida, bus.fim,
                 bus.db_estado, bus.addr_asteroide, bus.addr_tiro});
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; kill_clr = 1'b1; bus.inicia = 1'b0; bus.reset_maquinas = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0; kill_clr = 1'b0;
  endtask

  // Start one round from OCIOSO and count edges, sampling edge included,
  // until fim is seen.
  task automatic run_round(output int cyc);
    int g;
    mon_clr = 1'b1;
    @(negedge clock); #1 mon_clr = 1'b0;
    g = 0;
    while (bus.db_estado != 4'h0 && g < 50) begin @(negedge clock); #1; g++; end
    mon = 1'b1; bus.inicia = 1'b1;
    @(posedge clock); cyc = 1; #1 bus.inicia = 1'b0;
    while (!bus.fim && cyc < 500) begin @(posedge clock); cyc++; #1; end
    chk("fim_seen", int'(bus.fim), 1);
    @(negedge clock); #1 mon = 1'b0;
  endtask

  typedef struct {
    logic [15:0] ast;
    logic [7:0]  tiro;
    int          ha, ht, na;
    logic        vidas;
    int          cyc, pont, decr, mt, max_a;
  } vec_t;

  vec_t tab[6];

  initial begin
    int cyc, g;
    bus.inicia = 1'b0; bus.reset_maquinas = 1'b0; bus.vidas = 1'b1;

    //           ast        tiro    ha  ht  na  vidas cyc pont decr mt max_a
    tab[0] = '{16'h0000, 8'h00, -1, -1, -1, 1'b1, 41, 0, 0, 0, 15};
    tab[1] = '{16'h0020, 8'h04,  5,  2, -1, 1'b1, 45, 1, 0, 1, 15};
    tab[2] = '{16'h0008, 8'h00, -1, -1,  3, 1'b1, 42, 0, 1, 0, 15};
    tab[3] = '{16'h0008, 8'h00, -1, -1,  3, 1'b0, 17, 0, 1, 0,  3};
    tab[4] = '{16'h0001, 8'hFF, -1, -1, -1, 1'b1, 49, 0, 0, 8, 15};
    tab[5] = '{16'h0080, 8'h01,  7,  0,  7, 1'b1, 42, 0, 1, 1, 15};

    // Reset held with inicia high: everything stays idle and zero.
    reset = 1'b1; kill_clr = 1'b1; bus.inicia = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("reset_outs", outs_packed(), 0);
    end
    bus.inicia = 1'b0;
    @(negedge clock); reset = 1'b0; kill_clr = 1'b0;

    // Table-driven single rounds, each from a fresh reset (div_cnt = 0).
    for (int v = 0; v < 6; v++) begin
      do_reset();
      ast_init = tab[v].ast; tiro_init = tab[v].tiro;
      hit_a = tab[v].ha; hit_t = tab[v].ht; nave_a = tab[v].na;
      bus.vidas = tab[v].vidas;
      run_round(cyc);
      chk($sformatf("v%0d_cycles", v), cyc, tab[v].cyc);
      chk($sformatf("v%0d_pontua", v), n_pont, tab[v].pont);
      chk($sformatf("v%0d_decr", v), n_decr, tab[v].decr);
      chk($sformatf("v%0d_move_tiro", v), n_mt, tab[v].mt);
      chk($sformatf("v%0d_move_ast", v), n_ma, 0);
      chk($sformatf("v%0d_max_addr_ast", v), max_a, tab[v].max_a);
      chk($sformatf("v%0d_colisao_after_ship", v), col_at_nave, 0);
      if (tab[v].pont == 1) begin
        chk($sformatf("v%0d_pont_addr_ast", v), last_pont_a, tab[v].ha);
        chk($sformatf("v%0d_pont_addr_tiro", v), last_pont_t, tab[v].ht);
      end
      if (tab[v].decr == 1)
        chk($sformatf("v%0d_decr_addr", v), last_decr_a, tab[v].na);
      if (!tab[v].vidas)
        chk($sformatf("v%0d_fim_after_batida", v), fim_prev, 4);
    end

    // Four back-to-back empty rounds: the 4th also sweeps MOVE_AST.
    do_reset();
    ast_init = '0; tiro_init = '0; hit_a = -1; hit_t = -1; nave_a = -1; bus.vidas = 1'b1;
    for (int r = 0; r < 4; r++) begin
      run_round(cyc);
      chk($sformatf("div_round%0d_cycles", r), cyc, (r == 3) ? 57 : 41);
      chk($sformatf("div_round%0d_move_ast_states", r), n_mast_st, (r == 3) ? 16 : 0);
      chk($sformatf("div_round%0d_move_ast", r), n_ma, 0);
    end

    // reset_maquinas while in COLISAO: back to OCIOSO, indices 0, no fim.
    do_reset();
    ast_init = 16'h0001; tiro_init = '0;
    bus.inicia = 1'b1;
    @(posedge clock); #1 bus.inicia = 1'b0;
    g = 0;
    while (bus.db_estado != 4'h5 && g < 100) begin @(negedge clock); g++; end
    chk("reach_colisao", int'(bus.db_estado), 5);
    bus.reset_maquinas = 1'b1;
    @(posedge clock); #1;
    chk("rm_estado", int'(bus.db_estado), 0);
    chk("rm_outs", outs_packed(), 0);
    bus.reset_maquinas = 1'b0;
    g = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      g += int'(bus.fim) + int'(bus.db_estado != 4'h0);
    end
    chk("rm_no_fim_stays_idle", g, 0);

    // Async reset mid-round clears outputs without waiting for an edge.
    tiro_init = 8'h01;
    @(negedge clock); bus.inicia = 1'b1;
    @(posedge clock); #1 bus.inicia = 1'b0;
    chk("pre_async_move_tiro", int'(bus.move_tiro), 1);
    #1 reset = 1'b1;
    #1 chk("async_outs", outs_packed(), 0);
    @(negedge clock); reset = 1'b0;

    $display("test done: total=%0d bad=%0d", ncmp, nbad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
